// File: rtl/ctrl_mem_wb_pipe.sv
// ctrl_mem_wb_pipe: Execute->Memory->Writeback control pipeline with branch resolution and data-memory wait-state stalls.
// Define CTRL_PERF_CNT_EN to build the branch-taken and stall-cycle counters; otherwise those ports read 0.
module ctrl_mem_wb_pipe #(
  parameter logic [1:0]  LOAD_CODE = 2'b01,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteE,
  input  logic [1:0]       ResultSrcE,
  input  logic             MemWriteE,
  input  logic             JumpE,
  input  logic             BranchE,
  input  logic [2:0]       Funct3E,
  input  logic             ZeroE,
  input  logic             LtE,
  input  logic             LtuE,
  input  logic             FlushM,
  input  logic             MemReadyM,
  output logic             PCSrcE,
  output logic             StallM,
  output logic             RegWriteM,
  output logic [1:0]       ResultSrcM,
  output logic             MemWriteM,
  output logic             RegWriteW,
  output logic [1:0]       ResultSrcW,
  output logic [CNT_W-1:0] BranchTakenCnt,
  output logic [CNT_W-1:0] StallCycleCnt
);

  logic branch_cond;
  logic mem_op;
  logic stall;

  always_comb begin
    branch_cond = 1'b0;
    case (Funct3E)
      3'b000:  branch_cond = ZeroE;
      3'b001:  branch_cond = ~ZeroE;
      3'b100:  branch_cond = LtE;
      3'b101:  branch_cond = ~LtE;
      3'b110:  branch_cond = LtuE;
      3'b111:  branch_cond = ~LtuE;
      default: branch_cond = 1'b0;
    endcase
  end

  assign mem_op = MemWriteM | (ResultSrcM == LOAD_CODE);
  assign stall  = mem_op & ~MemReadyM;
  assign StallM = stall;
  // Redirect only when the E instruction actually advances into M.
  assign PCSrcE = (JumpE | (BranchE & branch_cond)) & ~stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= '0;
      MemWriteM  <= 1'b0;
      RegWriteW  <= 1'b0;
      ResultSrcW <= '0;
    end else begin
      if (FlushM) begin
        RegWriteM  <= 1'b0;
        ResultSrcM <= '0;
        MemWriteM  <= 1'b0;
      end else if (!stall) begin
        RegWriteM  <= RegWriteE;
        ResultSrcM <= ResultSrcE;
        MemWriteM  <= MemWriteE;
      end
      // A held M instruction sends a bubble so it writes back only once.
      if (stall) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= '0;
      end else begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
      end
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      branch_cnt <= branch_cnt + CNT_W'(PCSrcE);
      stall_cnt  <= stall_cnt + CNT_W'(stall);
    end
  end

  assign BranchTakenCnt = branch_cnt;
  assign StallCycleCnt  = stall_cnt;
`else
  assign BranchTakenCnt = '0;
  assign StallCycleCnt  = '0;
`endif

endmodule

// File: tb/tb_ctrl_mem_wb_pipe.sv
// Scoreboard bench for ctrl_mem_wb_pipe: directed scenarios then randomized traffic against a record-level reference model.
module tb_ctrl_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ZeroE, LtE, LtuE, FlushM, MemReadyM;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic        PCSrcE, StallM, RegWriteM, MemWriteM, RegWriteW;
  logic [1:0]  ResultSrcM, ResultSrcW;
  logic [31:0] BranchTakenCnt, StallCycleCnt;

  ctrl_mem_wb_pipe #(.LOAD_CODE(2'b01), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .Funct3E(Funct3E),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .FlushM(FlushM), .MemReadyM(MemReadyM),
    .PCSrcE(PCSrcE), .StallM(StallM),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
    .BranchTakenCnt(BranchTakenCnt), .StallCycleCnt(StallCycleCnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst_n;
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       jump;
    logic       branch;
    logic [2:0] f3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       flush;
    logic       ready;
  } stim_t;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
  } instr_t;

  typedef struct packed {
    logic        pcsrc;
    logic        stall;
    instr_t      m;
    logic        rw_w;
    logic [1:0]  rs_w;
    logic [31:0] cb;
    logic [31:0] cs;
  } exp_t;

  exp_t   sb[$];
  stim_t  cur;
  instr_t mdl_m;
  logic       mdl_rw_w;
  logic [1:0] mdl_rs_w;
  logic [31:0] mdl_cb, mdl_cs;
  int checks = 0;
  int errors = 0;

  function automatic logic taken(stim_t s);
    case (s.f3)
      3'd0: return s.zero;
      3'd1: return !s.zero;
      3'd4: return s.lt;
      3'd5: return !s.lt;
      3'd6: return s.ltu;
      3'd7: return !s.ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic m_waiting(stim_t s);
    return (mdl_m.mw || mdl_m.rs == 2'b01) && !s.ready;
  endfunction

  function automatic logic redirect(stim_t s);
    return (s.jump || (s.branch && taken(s))) && !m_waiting(s);
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1'b1;
    s.ready = 1'b1;
    return s;
  endfunction

  task automatic clear_model();
    mdl_m = '0; mdl_rw_w = 1'b0; mdl_rs_w = 2'b00; mdl_cb = 0; mdl_cs = 0;
  endtask

  // Reference model advances by whole instruction records at each clock edge.
  task automatic advance(stim_t s);
    logic hold, redir;
    instr_t e;
    if (!s.rst_n) begin
      clear_model();
      return;
    end
    hold  = m_waiting(s);
    redir = redirect(s);
`ifdef CTRL_PERF_CNT_EN
    mdl_cb = mdl_cb + (redir ? 1 : 0);
    mdl_cs = mdl_cs + (hold ? 1 : 0);
`endif
    if (hold) begin
      mdl_rw_w = 1'b0; mdl_rs_w = 2'b00;
    end else begin
      mdl_rw_w = mdl_m.rw; mdl_rs_w = mdl_m.rs;
    end
    e.rw = s.rw; e.rs = s.rs; e.mw = s.mw;
    if (s.flush) mdl_m = '0;
    else if (!hold) mdl_m = e;
  endtask

  task automatic apply(stim_t s);
    reset = s.rst_n; RegWriteE = s.rw; ResultSrcE = s.rs; MemWriteE = s.mw;
    JumpE = s.jump; BranchE = s.branch; Funct3E = s.f3; ZeroE = s.zero;
    LtE = s.lt; LtuE = s.ltu; FlushM = s.flush; MemReadyM = s.ready;
  endtask

  // One cycle: model absorbs the edge, new inputs land mid-cycle (reset too), expectation queued.
  task automatic step(stim_t s);
    exp_t x;
    @(posedge clk);
    advance(cur);
    #2;
    cur = s;
    apply(s);
    if (!s.rst_n) clear_model();
    #1;
    x.pcsrc = redirect(s);
    x.stall = m_waiting(s);
    x.m = mdl_m; x.rw_w = mdl_rw_w; x.rs_w = mdl_rs_w;
    x.cb = mdl_cb; x.cs = mdl_cs;
    sb.push_back(x);
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        cmp("PCSrcE",         32'(PCSrcE),     32'(x.pcsrc));
        cmp("StallM",         32'(StallM),     32'(x.stall));
        cmp("RegWriteM",      32'(RegWriteM),  32'(x.m.rw));
        cmp("ResultSrcM",     32'(ResultSrcM), 32'(x.m.rs));
        cmp("MemWriteM",      32'(MemWriteM),  32'(x.m.mw));
        cmp("RegWriteW",      32'(RegWriteW),  32'(x.rw_w));
        cmp("ResultSrcW",     32'(ResultSrcW), 32'(x.rs_w));
        cmp("BranchTakenCnt", BranchTakenCnt,  x.cb);
        cmp("StallCycleCnt",  StallCycleCnt,   x.cs);
      end
    end
  end

  initial begin : driver
    stim_t s, ld;
    clear_model();
    cur = idle();
    cur.rst_n = 1'b0;
    apply(cur);
    step(cur);
    step(cur);

    // ALU write flowing through M and W with no stall
    s = idle(); s.rw = 1'b1;
    repeat (3) step(s);

    // branch condition sweep
    s = idle(); s.branch = 1'b1;
    s.f3 = 3'b000; s.zero = 1'b1; step(s);
    s.zero = 1'b0; s.f3 = 3'b101; s.lt = 1'b1; step(s);
    s.lt = 1'b0; s.f3 = 3'b110; s.ltu = 1'b1; step(s);
    s.f3 = 3'b010; s.zero = 1'b1; s.lt = 1'b1; step(s);
    s.f3 = 3'b011; step(s);
    s.branch = 1'b0; s.jump = 1'b1; step(s);

    // load stalled for three cycles then released
    ld = idle(); ld.rw = 1'b1; ld.rs = 2'b01;
    step(ld);
    s = idle(); s.ready = 1'b0;
    repeat (3) step(s);
    s = idle(); step(s); step(s); step(s);

    // flush during a stall
    s = idle(); s.mw = 1'b1; step(s);
    s = idle(); s.ready = 1'b0; step(s);
    s.flush = 1'b1; step(s);
    s = idle(); step(s);

    // asynchronous reset in the middle of a stall
    step(ld);
    s = idle(); s.ready = 1'b0; step(s);
    s.rst_n = 1'b0; step(s);
    s = idle(); step(s);

    // taken branch waiting behind a stalled load
    step(ld);
    s = idle(); s.ready = 1'b0; s.branch = 1'b1; s.f3 = 3'b000; s.zero = 1'b1;
    step(s); step(s);
    s.ready = 1'b1; step(s);
    s = idle(); step(s); step(s);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      s.rst_n  = ($urandom_range(0, 59) != 0);
      s.rw     = 1'($urandom);
      s.rs     = 2'($urandom);
      s.mw     = ($urandom_range(0, 3) == 0);
      s.jump   = ($urandom_range(0, 7) == 0);
      s.branch = 1'($urandom);
      s.f3     = 3'($urandom);
      s.zero   = 1'($urandom);
      s.lt     = 1'($urandom);
      s.ltu    = 1'($urandom);
      s.flush  = ($urandom_range(0, 9) == 0);
      s.ready  = ($urandom_range(0, 2) != 0);
      step(s);
    end

    repeat (3) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_mem_wb_pipe.md
Name: ctrl_mem_wb_pipe

Overview:
Control-path pipeline for the Execute→Memory→Writeback span of the 5-stage RV32I core. It sits directly downstream of the D→E control register. It resolves PCSrcE from the branch/jump controls and ALU flags, then carries the write controls through the E/M and M/W registers. It also absorbs data-memory wait states by stalling M and inserting a bubble into W.

Parameters:
LOAD_CODE, 2'b01, ResultSrc encoding that marks a load (memory read data selected in W).
CNT_W, 32, width of the optional performance counters.

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  asynchronous, active-low reset.
RegWriteE  in  1  register write enable from the E stage.
ResultSrcE  in  2  result select from the E stage.
MemWriteE  in  1  store enable from the E stage.
JumpE  in  1  jal/jalr in E.
BranchE  in  1  conditional branch in E.
Funct3E  in  3  branch condition code.
ZeroE  in  1  ALU result == 0.
LtE  in  1  signed SrcA < SrcB.
LtuE  in  1  unsigned SrcA < SrcB.
FlushM  in  1  load a bubble into E/M.
MemReadyM  in  1  data memory completes the access this cycle.
PCSrcE  out  1  redirect fetch (combinational).
StallM  out  1  M stage held (combinational, to hazard unit).
RegWriteM  out  1  registered.
ResultSrcM  out  2  registered.
MemWriteM  out  1  registered.
RegWriteW  out  1  registered.
ResultSrcW  out  2  registered.
BranchTakenCnt  out  CNT_W  optional counter (see Optional Feature).
StallCycleCnt  out  CNT_W  optional counter (see Optional Feature).

Behaviour:
- reset low, asynchronously: RegWriteM, ResultSrcM, MemWriteM, RegWriteW, ResultSrcW all go to 0. Both counters go to 0.
- Branch condition by Funct3E:
  - 000 → ZeroE
  - 001 → !ZeroE
  - 100 → LtE
  - 101 → !LtE
  - 110 → LtuE
  - 111 → !LtuE
  - 010 and 011 → 0
- PCSrcE = (JumpE | (BranchE & cond)) & !StallM. Gating on !StallM means the redirect fires only in the cycle the E instruction actually advances.
- MemOpM = MemWriteM | (ResultSrcM == LOAD_CODE).
- StallM = MemOpM & !MemReadyM.
- E/M register, priority FlushM > StallM > load, evaluated per clock edge:
  - FlushM=1: clear RegWriteM, MemWriteM, ResultSrcM to 0. Flush wins over a simultaneous stall.
  - StallM=1 (and no flush): hold all M values.
  - Otherwise: load the *E inputs.
- M/W register:
  - StallM=1: RegWriteW=0, ResultSrcW=0 (bubble). The held M instruction must not write back twice.
  - Otherwise: load the M values.
- Latency: E→M is 1 cycle, M→W is 1 cycle, plus one extra cycle for each cycle MemReadyM is low during a memory op.
- MemReadyM is ignored when M holds no memory op; no stall is possible then.
- A multi-cycle stall holds M values stable for every stalled cycle. The instruction is released into W on the first edge with MemReadyM=1.
- Reset asserted mid-stall: all registers clear immediately. StallM drops to 0 because MemOpM becomes 0.

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined:
  - BranchTakenCnt increments by 1 on each edge where PCSrcE=1.
  - StallCycleCnt increments on each edge where StallM=1.
  - Both counters wrap modulo 2^CNT_W and are cleared by reset.
- Undefined:
  - Both ports remain present and are tied to 0.
  - No counter flops are synthesized.

Test Plan:
1. Reset released; drive RegWriteE=1, ResultSrcE=2'b00, MemReadyM=1 → RegWriteM=1 after 1 edge, RegWriteW=1 after 2 edges, StallM=0 throughout.
2. Branch sweep with BranchE=1:
   - Funct3E=000, ZeroE=1 → PCSrcE=1.
   - Funct3E=101, LtE=1 → PCSrcE=0.
   - Funct3E=110, LtuE=1 → PCSrcE=1.
   - Funct3E=010 → PCSrcE=0.
   - JumpE=1 with any flags → PCSrcE=1.
3. Load with ResultSrcE=01, MemReadyM held low for 3 cycles once in M → StallM=1 for 3 cycles, M values held, RegWriteW=0 for those 3 cycles. The next edge gives RegWriteW=1, ResultSrcW=01. With CTRL_PERF_CNT_EN, StallCycleCnt=3.
4. FlushM=1 together with StallM=1 → RegWriteM=0, MemWriteM=0, ResultSrcM=0 on the next edge; StallM falls to 0.
5. reset driven low asynchronously mid-stall (between edges) → all registered outputs are 0 immediately, StallM=0; counters are 0 when CTRL_PERF_CNT_EN is defined.
6. Taken branch while StallM=1 → PCSrcE=0 until MemReadyM=1, then PCSrcE=1 for exactly one cycle. With CTRL_PERF_CNT_EN, BranchTakenCnt increments by exactly 1.
